// File: rtl/oscillator_period_meter_pkg.sv
// Shared sensor package for the oscillator period meter: FSM state type and counter sizing.
package oscillator_period_meter_pkg;

   localparam int unsigned PERIOD_BITS_DEFAULT = 16;
   localparam int unsigned SYNC_STAGES_DEFAULT = 2;

   // Saturation value of the period counter at the default width
   localparam logic [PERIOD_BITS_DEFAULT-1:0] CNT_MAX_DEFAULT = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } meter_state_t;

endpackage

// File: rtl/oscillator_period_meter_if.sv
// Period sample bus from the meter (master) to the filtering/accumulation stage (slave).
interface oscillator_period_meter_if
   import oscillator_period_meter_pkg::*;
#(
   parameter int unsigned PERIOD_BITS = PERIOD_BITS_DEFAULT
) ();

   logic [PERIOD_BITS-1:0] PERIOD_OUT;
   logic                   PERIOD_VALID;
   logic                   OVERFLOW;
   logic                   BUSY;

   modport master (
      output PERIOD_OUT,
      output PERIOD_VALID,
      output OVERFLOW,
      output BUSY
   );

   modport slave (
      input PERIOD_OUT,
      input PERIOD_VALID,
      input OVERFLOW,
      input BUSY
   );

endinterface

// File: rtl/oscillator_period_meter_sync_edge_detect.sv
// Synchronizes FREQ_IN into CLK and flags its rising edges.
// PERIOD_METER_GLITCH_FILTER_EN: accept an edge only after 0,0,1,1 on the synchronized input.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic FREQ_IN,
   output logic EDGE_PULSE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;

   assign sync_last = sync_q[SYNC_STAGES-1];

   // Metastability chain; bit 0 takes the raw asynchronous input
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], FREQ_IN};
      end
   end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
   // Three cycles of history: edge needs two lows followed by two highs
   logic [2:0] hist_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hist_q <= '0;
      end else begin
         hist_q <= {hist_q[1:0], sync_last};
      end
   end

   assign EDGE_PULSE = sync_last & hist_q[0] & ~hist_q[1] & ~hist_q[2];
`else
   logic hist_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hist_q <= 1'b0;
      end else begin
         hist_q <= sync_last;
      end
   end

   assign EDGE_PULSE = sync_last & ~hist_q;
`endif

endmodule

// File: rtl/oscillator_period_meter.sv
// Measures the theremin oscillator period in CLK cycles; one sample per rising edge.
// Optional macro PERIOD_METER_GLITCH_FILTER_EN enables the glitch filter in sync_edge_detect.
module oscillator_period_meter
   import oscillator_period_meter_pkg::*;
#(
   parameter int unsigned PERIOD_BITS = PERIOD_BITS_DEFAULT,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic                      CE,
   input  logic                      FREQ_IN,
   oscillator_period_meter_if.master meter_bus
);

   localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;

   meter_state_t           state_q, state_d;
   logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q, valid_d;
   logic                   busy_q;
   logic                   edge_pulse;
   logic                   cnt_at_max;
   logic [PERIOD_BITS-1:0] cnt_sat_inc;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge_detect (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .FREQ_IN    (FREQ_IN),
      .EDGE_PULSE (edge_pulse)
   );

   assign cnt_at_max  = (cnt_q == CNT_MAX);
   assign cnt_sat_inc = cnt_at_max ? CNT_MAX : PERIOD_BITS'(cnt_q + 1'b1);

   // Next state, counter and sample; CE low always wins over a coincident edge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (CE) begin
               state_d = ARM;
            end
         end
         ARM: begin
            cnt_d = '0;
            if (!CE) begin
               state_d = IDLE;
            end else if (edge_pulse) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (!CE) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (edge_pulse) begin
               period_d = cnt_sat_inc;
               ovf_d    = cnt_at_max;
               valid_d  = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_sat_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= (state_d == MEASURE);
      end
   end

   assign meter_bus.PERIOD_OUT   = period_q;
   assign meter_bus.PERIOD_VALID = valid_q;
   assign meter_bus.OVERFLOW     = ovf_q;
   assign meter_bus.BUSY         = busy_q;

endmodule

// File: tb/tb_oscillator_period_meter.sv
// Directed self-checking bench for oscillator_period_meter (16-bit and 8-bit instances).
module tb_oscillator_period_meter;
   import oscillator_period_meter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic ce16, ce8;
   logic osc_q = 1'b0;
   logic spike = 1'b0;
   logic freq_in;
   bit   osc_en = 1'b0;
   int   per = 10;
   int   pend = 10;
   int   ph = 0;

   int n_checks = 0;
   int n_pass = 0;

   logic [16:0] q16[$];
   logic [8:0]  q8[$];
   logic        prev16 = 1'b0, prev8 = 1'b0;
   int          dbl16 = 0, dbl8 = 0;

   oscillator_period_meter_if #(.PERIOD_BITS(16)) bus16 ();
   oscillator_period_meter_if #(.PERIOD_BITS(8))  bus8 ();

   oscillator_period_meter #(.PERIOD_BITS(16), .SYNC_STAGES(2)) u_dut16 (
      .CLK (clk), .RESET_N (rst_n), .CE (ce16), .FREQ_IN (freq_in), .meter_bus (bus16)
   );

   oscillator_period_meter #(.PERIOD_BITS(8), .SYNC_STAGES(2)) u_dut8 (
      .CLK (clk), .RESET_N (rst_n), .CE (ce8), .FREQ_IN (freq_in), .meter_bus (bus8)
   );

   always #5 clk = ~clk;

   assign freq_in = osc_q | spike;

   // Oscillator: rising edge at every wrap; a new period takes effect only at a wrap
   always @(negedge clk) begin
      if (!osc_en) begin
         ph    = 0;
         per   = pend;
         osc_q = 1'b0;
      end else begin
         if (ph + 1 >= per) begin
            ph  = 0;
            per = pend;
         end else begin
            ph = ph + 1;
         end
         osc_q = (ph < per / 2);
      end
   end

   // Sample collector and back-to-back strobe detector
   always @(negedge clk) begin
      if (bus16.PERIOD_VALID) begin
         q16.push_back({bus16.OVERFLOW, bus16.PERIOD_OUT});
         if (prev16) dbl16++;
      end
      if (bus8.PERIOD_VALID) begin
         q8.push_back({bus8.OVERFLOW, bus8.PERIOD_OUT});
         if (prev8) dbl8++;
      end
      prev16 = bus16.PERIOD_VALID;
      prev8  = bus8.PERIOD_VALID;
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wait_q16(input int n, input int budget, input string tag);
      int c = 0;
      while (q16.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      check({tag, "_samples"}, longint'(q16.size() >= n), 1);
   endtask

   task automatic wait_q8(input int n, input int budget, input string tag);
      int c = 0;
      while (q8.size() < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      check({tag, "_samples"}, longint'(q8.size() >= n), 1);
   endtask

   function automatic logic [16:0] s16(input int i);
      if (i < q16.size()) return q16[i];
      return 'x;
   endfunction

   function automatic logic [8:0] s8(input int i);
      if (i < q8.size()) return q8[i];
      return 'x;
   endfunction

   initial begin
      rst_n = 1'b0;
      ce16  = 1'b0;
      ce8   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_period",   bus16.PERIOD_OUT, 0);
      check("rst_valid",    bus16.PERIOD_VALID, 0);
      check("rst_overflow", bus16.OVERFLOW, 0);
      check("rst_busy",     bus16.BUSY, 0);
      rst_n = 1'b1;

      // CE low: oscillator running, meter must stay silent
      pend   = 10;
      osc_en = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("ce0_no_strobe", q16.size(), 0);
      check("ce0_busy",      bus16.BUSY, 0);
      check("ce0_period",    bus16.PERIOD_OUT, 0);

      // CE high, period 10: ARM edge is silent, every later edge reports 10
      @(posedge clk); #2 ce16 = 1'b1;
      wait_q16(3, 100, "p10");
      check("p10_s0", s16(0), {1'b0, 16'd10});
      check("p10_s1", s16(1), {1'b0, 16'd10});
      check("p10_s2", s16(2), {1'b0, 16'd10});
      @(negedge clk);
      check("p10_busy", bus16.BUSY, 1);

      // Period change 10 -> 37 at an oscillator wrap
      q16.delete();
      wait_q16(1, 30, "sw_sync");
      q16.delete();
      pend = 37;
      wait_q16(3, 150, "p37");
      check("p37_s0", s16(0), {1'b0, 16'd10});
      check("p37_s1", s16(1), {1'b0, 16'd37});
      check("p37_s2", s16(2), {1'b0, 16'd37});

      // CE dropped for 5 cycles mid-period: partial period discarded, then re-arm
      q16.delete();
      repeat (10) @(posedge clk);
      #2 ce16 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("cedrop_busy",      bus16.BUSY, 0);
      check("cedrop_no_strobe", q16.size(), 0);
      check("cedrop_hold",      bus16.PERIOD_OUT, 37);
      @(posedge clk); #2 ce16 = 1'b1;
      wait_q16(1, 120, "rearm");
      check("rearm_s0", s16(0), {1'b0, 16'd37});

      // Back to period 10, then async reset mid-measurement
      q16.delete();
      pend = 10;
      wait_q16(3, 200, "pre_rst");
      check("pre_rst_s2", s16(2), {1'b0, 16'd10});
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_period", bus16.PERIOD_OUT, 0);
      check("arst_busy",   bus16.BUSY, 0);
      check("arst_ovf",    bus16.OVERFLOW, 0);
      check("arst_valid",  bus16.PERIOD_VALID, 0);
      repeat (3) @(posedge clk);
      do @(posedge clk); while (osc_q !== 1'b0);
      q16.delete();
      #2 rst_n = 1'b1;
      wait_q16(1, 40, "post_rst");
      check("post_rst_s0", s16(0), {1'b0, 16'd10});

      // 8-bit instance: 300-cycle period saturates, then 20 reports cleanly
      ce16 = 1'b0;
      pend = 300;
      repeat (320) @(posedge clk);
      q8.delete();
      #2 ce8 = 1'b1;
      wait_q8(2, 1000, "p300");
      check("p300_s0", s8(0), {1'b1, 8'd255});
      check("p300_s1", s8(1), {1'b1, 8'd255});
      q8.delete();
      pend = 20;
      wait_q8(2, 700, "p20");
      check("p20_s0", s8(0), {1'b1, 8'd255});
      check("p20_s1", s8(1), {1'b0, 8'd20});
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("p20_hold_period", bus8.PERIOD_OUT, 20);
      check("p20_hold_ovf",    bus8.OVERFLOW, 0);
      ce8 = 1'b0;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
      // Single-cycle spike in the low phase must not be taken as an edge
      q16.delete();
      @(posedge clk); #2 ce16 = 1'b1;
      wait_q16(2, 100, "gf_pre");
      q16.delete();
      wait_q16(1, 30, "gf_sync");
      q16.delete();
      repeat (8) @(posedge clk);
      #2 spike = 1'b1;
      @(posedge clk); #2 spike = 1'b0;
      wait_q16(2, 100, "gf");
      check("gf_s0", s16(0), {1'b0, 16'd20});
      check("gf_s1", s16(1), {1'b0, 16'd20});
      ce16 = 1'b0;
`endif

      check("no_double_strobe16", dbl16, 0);
      check("no_double_strobe8",  dbl8, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
